ula_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational full ALU: same op_sel/num_mode encoding and flag set.
- Adds a valid/ready handshake, a two-register pipeline with back-pressure, and a reserved-mode error flag.
- Sits between an operand producer (sequencer/FIFO) and a result consumer in the datapath.

---
 rtl/ula_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_ula_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_pipe.sv
// ula_pipe: two-stage pipelined ALU with valid/ready handshake and back-pressure.
// Stage 1 holds the operand set; stage 2 holds the computed result and flags.
// Optional sticky overflow/saturate accumulation: define ULA_PIPE_STICKY_FLAGS_EN.
module ula_pipe #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op_sel,
  input  logic [2:0]       num_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_overflow,
  output logic             flag_saturate,
  output logic             flag_zero,
  output logic             flag_negative,
  output logic             flag_carry,
  output logic             flag_error,
  input  logic             sticky_clear,
  output logic             sticky_ov,
  output logic             sticky_sat
);

  localparam int SW = $clog2(WIDTH);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [2:0]       s1_op, s1_mode;
  logic             s2_load;

  logic [WIDTH:0]     add_u, sub_u, add_s, sub_s, shl_ext, shr_ext;
  logic [2*WIDTH-1:0] mul_u, mul_s, mul_q;
  logic [SW-1:0]      amt;
  logic               signed_m, sat_m, exact_neg;
  logic [WIDTH-1:0]   wrap, sat_val, c_res;
  logic               c_ov, c_sat, c_carry, c_zero, c_neg, c_err;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // exact-width arithmetic: W+1 bit add/sub, 2W bit products, one extra bit to catch shifted-out carry
  assign add_u = {1'b0, s1_a} + {1'b0, s1_b};
  assign sub_u = {1'b0, s1_a} - {1'b0, s1_b};
  assign add_s = {s1_a[WIDTH-1], s1_a} + {s1_b[WIDTH-1], s1_b};
  assign sub_s = {s1_a[WIDTH-1], s1_a} - {s1_b[WIDTH-1], s1_b};
  assign mul_u = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
  assign mul_s = {{WIDTH{s1_a[WIDTH-1]}}, s1_a} * {{WIDTH{s1_b[WIDTH-1]}}, s1_b};
  assign mul_q = $signed(mul_s) >>> FRAC;
  assign amt   = s1_b[SW-1:0];

  // stage 2 datapath: wrapped result, overflow detection, saturation and flag generation
  always_comb begin
    signed_m  = (s1_mode == 3'd1) || (s1_mode == 3'd3) || (s1_mode == 3'd4);
    sat_m     = (s1_mode == 3'd2) || (s1_mode == 3'd3) || (s1_mode == 3'd4);
    wrap      = '0;
    c_ov      = 1'b0;
    c_carry   = 1'b0;
    exact_neg = 1'b0;
    shl_ext   = {1'b0, s1_a} << amt;
    if (signed_m) shr_ext = $signed({s1_a, 1'b0}) >>> amt;
    else          shr_ext = {s1_a, 1'b0} >> amt;

    case (s1_op)
      3'd0: begin
        wrap    = add_u[WIDTH-1:0];
        c_carry = add_u[WIDTH];
        if (signed_m) begin
          c_ov      = add_s[WIDTH] ^ add_s[WIDTH-1];
          exact_neg = add_s[WIDTH];
        end else begin
          c_ov = add_u[WIDTH];
        end
      end
      3'd1: begin
        wrap    = sub_u[WIDTH-1:0];
        c_carry = sub_u[WIDTH];
        if (signed_m) begin
          c_ov      = sub_s[WIDTH] ^ sub_s[WIDTH-1];
          exact_neg = sub_s[WIDTH];
        end else begin
          c_ov      = sub_u[WIDTH];
          exact_neg = sub_u[WIDTH];
        end
      end
      3'd2: begin
        if (s1_mode == 3'd4) begin
          wrap      = mul_q[WIDTH-1:0];
          c_ov      = !((&mul_q[2*WIDTH-1:WIDTH-1]) || !(|mul_q[2*WIDTH-1:WIDTH-1]));
          exact_neg = mul_q[2*WIDTH-1];
        end else if (signed_m) begin
          wrap      = mul_s[WIDTH-1:0];
          c_ov      = !((&mul_s[2*WIDTH-1:WIDTH-1]) || !(|mul_s[2*WIDTH-1:WIDTH-1]));
          exact_neg = mul_s[2*WIDTH-1];
        end else begin
          wrap = mul_u[WIDTH-1:0];
          c_ov = |mul_u[2*WIDTH-1:WIDTH];
        end
      end
      3'd3: wrap = s1_a & s1_b;
      3'd4: wrap = s1_a | s1_b;
      3'd5: wrap = s1_a ^ s1_b;
      3'd6: begin
        wrap    = shl_ext[WIDTH-1:0];
        c_carry = shl_ext[WIDTH];
      end
      3'd7: begin
        wrap    = shr_ext[WIDTH:1];
        c_carry = shr_ext[0];
      end
    endcase

    if (signed_m) sat_val = exact_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else          sat_val = exact_neg ? '0 : '1;

    c_sat  = c_ov && sat_m;
    c_res  = c_sat ? sat_val : wrap;
    c_zero = (c_res == '0);
    c_neg  = signed_m && c_res[WIDTH-1];
    c_err  = 1'b0;

    // reserved modes force a zero result with only the error flag set
    if (s1_mode > 3'd4) begin
      c_res   = '0;
      c_ov    = 1'b0;
      c_sat   = 1'b0;
      c_zero  = 1'b0;
      c_neg   = 1'b0;
      c_carry = 1'b0;
      c_err   = 1'b1;
    end
  end

  // stage 1: capture operand set whenever the slot is free or advancing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_mode  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= op_a;
        s1_b    <= op_b;
        s1_op   <= op_sel;
        s1_mode <= num_mode;
      end
    end
  end

  // stage 2: register result and flags; held stable while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      result        <= '0;
      flag_overflow <= 1'b0;
      flag_saturate <= 1'b0;
      flag_zero     <= 1'b0;
      flag_negative <= 1'b0;
      flag_carry    <= 1'b0;
      flag_error    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result        <= c_res;
        flag_overflow <= c_ov;
        flag_saturate <= c_sat;
        flag_zero     <= c_zero;
        flag_negative <= c_neg;
        flag_carry    <= c_carry;
        flag_error    <= c_err;
      end
    end
  end

`ifdef ULA_PIPE_STICKY_FLAGS_EN
  logic xfer;
  assign xfer = out_valid && out_ready;

  // sticky accumulation of transferred flags; a clear keeps only a coincident transfer's flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ov  <= 1'b0;
      sticky_sat <= 1'b0;
    end else if (sticky_clear) begin
      sticky_ov  <= xfer && flag_overflow;
      sticky_sat <= xfer && flag_saturate;
    end else if (xfer) begin
      sticky_ov  <= sticky_ov  | flag_overflow;
      sticky_sat <= sticky_sat | flag_saturate;
    end
  end
`else
  logic unused_sticky_clear;
  assign unused_sticky_clear = sticky_clear;
  assign sticky_ov  = 1'b0;
  assign sticky_sat = 1'b0;
`endif

endmodule

// File: tb/tb_ula_pipe.sv
// Testbench for ula_pipe (WIDTH=8, FRAC=4): directed steps plus a randomized
// scoreboarded stream checked against an arithmetic reference model.
module tb_ula_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] op_a, op_b, result;
  logic [2:0] op_sel, num_mode;
  logic       flag_overflow, flag_saturate, flag_zero, flag_negative, flag_carry, flag_error;
  logic       sticky_clear, sticky_ov, sticky_sat;

  int tests  = 0;
  int failed = 0;

`ifdef ULA_PIPE_STICKY_FLAGS_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  ula_pipe #(.WIDTH(8), .FRAC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .num_mode(num_mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_overflow(flag_overflow), .flag_saturate(flag_saturate),
    .flag_zero(flag_zero), .flag_negative(flag_negative),
    .flag_carry(flag_carry), .flag_error(flag_error),
    .sticky_clear(sticky_clear), .sticky_ov(sticky_ov), .sticky_sat(sticky_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {result, ov, sat, zero, neg, carry, err} from plain integer arithmetic
  function automatic logic [13:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op, input logic [2:0] mode);
    longint ua, ub, sa, sb, ex, lo, hi, p, d;
    int amt;
    logic [7:0] r;
    logic ov, sat, c, sg, st;
    ua = a; ub = b;
    sa = a[7] ? ua - 256 : ua;
    sb = b[7] ? ub - 256 : ub;
    if (mode > 3'd4) return {8'h00, 6'b000001};
    sg  = (mode == 3'd1) || (mode == 3'd3) || (mode == 3'd4);
    st  = (mode >= 3'd2);
    lo  = sg ? -128 : 0;
    hi  = sg ? 127 : 255;
    ov  = 1'b0; sat = 1'b0; c = 1'b0; r = 8'h00; ex = 0;
    amt = int'(ub % 8);
    case (op)
      3'd0, 3'd1, 3'd2: begin
        if (op == 3'd0) begin
          ex = sg ? sa + sb : ua + ub;
          c  = (ua + ub) > 255;
        end else if (op == 3'd1) begin
          ex = sg ? sa - sb : ua - ub;
          c  = ua < ub;
        end else if (mode == 3'd4) begin
          p  = sa * sb;
          ex = p / 16;
          if (p < 0 && (p % 16) != 0) ex = ex - 1;
        end else begin
          ex = sg ? sa * sb : ua * ub;
        end
        ov  = (ex < lo) || (ex > hi);
        sat = ov && st;
        if (sat) r = (ex > hi) ? hi[7:0] : lo[7:0];
        else     r = ex[7:0];
      end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin
        ex = ua * (64'sd1 << amt);
        r  = ex[7:0];
        c  = (amt > 0) && (((ua >> (8 - amt)) & 1) != 0);
      end
      3'd7: begin
        d = 64'sd1 << amt;
        if (sg) begin
          ex = sa / d;
          if (sa < 0 && (sa % d) != 0) ex = ex - 1;
        end else begin
          ex = ua / d;
        end
        r = ex[7:0];
        c = (amt > 0) && (((ua >> (amt - 1)) & 1) != 0);
      end
    endcase
    return {r, ov, sat, (r == 8'h00), (sg && r[7]), c, 1'b0};
  endfunction

  function automatic logic [13:0] obs_pack();
    return {result, flag_overflow, flag_saturate, flag_zero, flag_negative, flag_carry, flag_error};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [2:0] mode);
    in_valid = 1'b1; op_a = a; op_b = b; op_sel = op; num_mode = mode;
  endtask

  // one op with out_ready high: absent one cycle after accept, present the next
  task automatic send_and_check(input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] op, input logic [2:0] mode, input string tag);
    @(negedge clk);
    drive(a, b, op, mode);
    #1 check({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2"}, out_valid, 1);
    check(tag, obs_pack(), model(a, b, op, mode));
  endtask

  logic [13:0] sb[$];
  logic [13:0] e1, e2, e3, hold_val, exp_v;
  logic        held;
  int          budget;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_sel = '0; num_mode = '0;
    out_ready = 1'b1; sticky_clear = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", obs_pack(), 0);
    check("rst_sticky", {sticky_ov, sticky_sat}, 0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    // directed arithmetic cases with literal expectations
    send_and_check(8'h70, 8'h20, 3'd0, 3'd3, "m3_add");
    check("m3_add_lit", obs_pack(), {8'h7F, 6'b110000});
    send_and_check(8'hF0, 8'h20, 3'd0, 3'd0, "m0_add");
    check("m0_add_lit", obs_pack(), {8'h10, 6'b100010});
    send_and_check(8'h05, 8'h09, 3'd1, 3'd2, "m2_sub");
    check("m2_sub_lit", obs_pack(), {8'h00, 6'b111010});
    send_and_check(8'h18, 8'h20, 3'd2, 3'd4, "m4_mul1");
    check("m4_mul1_lit", obs_pack(), {8'h30, 6'b000000});
    send_and_check(8'h40, 8'h40, 3'd2, 3'd4, "m4_mul2");
    check("m4_mul2_lit", obs_pack(), {8'h7F, 6'b110000});
    send_and_check(8'h90, 8'h01, 3'd7, 3'd1, "m1_shr");
    check("m1_shr_lit", obs_pack(), {8'hC8, 6'b000100});
    send_and_check(8'h81, 8'h03, 3'd6, 3'd0, "m0_shl");
    send_and_check(8'h80, 8'h01, 3'd1, 3'd3, "m3_sub_sat");
    send_and_check(8'hF8, 8'h08, 3'd2, 3'd4, "m4_mul_neg");
    send_and_check(8'h12, 8'h34, 3'd0, 3'd5, "rsv5");
    check("rsv5_lit", obs_pack(), {8'h00, 6'b000001});
    send_and_check(8'hFF, 8'hFF, 3'd2, 3'd7, "rsv7");

    // back-pressure: two entries fill the pipe, third offer waits
    e1 = model(8'h33, 8'h44, 3'd0, 3'd0);
    e2 = model(8'h7F, 8'h02, 3'd2, 3'd3);
    e3 = model(8'hAA, 8'h0F, 3'd5, 3'd0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(8'h33, 8'h44, 3'd0, 3'd0);
    #1 check("bp_rdy1", in_ready, 1);
    @(negedge clk);
    drive(8'h7F, 8'h02, 3'd2, 3'd3);
    #1 check("bp_rdy2", in_ready, 1);
    @(negedge clk);
    drive(8'hAA, 8'h0F, 3'd5, 3'd0);
    #1 check("bp_rdy3", in_ready, 0);
    check("bp_out1", obs_pack(), e1);
    @(negedge clk);
    #1 check("bp_rdy3_hold", in_ready, 0);
    check("bp_stall_valid", out_valid, 1);
    check("bp_stall_stable", obs_pack(), e1);
    out_ready = 1'b1;
    #1 check("bp_rdy_open", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out2", {out_valid, obs_pack()}, {1'b1, e2});
    @(negedge clk);
    check("bp_out3", {out_valid, obs_pack()}, {1'b1, e3});
    @(negedge clk);
    check("bp_empty", out_valid, 0);

    // reset with two entries in flight
    @(negedge clk);
    out_ready = 1'b0;
    drive(8'h11, 8'h22, 3'd0, 3'd0);
    @(negedge clk);
    drive(8'h33, 8'h01, 3'd6, 3'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1 check("mid_rst_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_and_check(8'h21, 8'h13, 3'd1, 3'd1, "post_rst");

    // sticky flags
    @(negedge clk);
    sticky_clear = 1'b1;
    @(negedge clk);
    sticky_clear = 1'b0;
    check("stk_clr0", {sticky_ov, sticky_sat}, 0);
    send_and_check(8'h70, 8'h20, 3'd0, 3'd3, "stk_op");
    @(negedge clk);
    check("stk_set", {sticky_ov, sticky_sat}, {STK, STK});
    @(negedge clk);
    check("stk_hold", {sticky_ov, sticky_sat}, {STK, STK});
    sticky_clear = 1'b1;
    @(negedge clk);
    sticky_clear = 1'b0;
    check("stk_clr1", {sticky_ov, sticky_sat}, 0);
    send_and_check(8'hF0, 8'h20, 3'd0, 3'd0, "stk_ov_only");
    sticky_clear = 1'b1;
    @(negedge clk);
    sticky_clear = 1'b0;
    check("stk_clr_xfer", {sticky_ov, sticky_sat}, {STK, 1'b0});

    // randomized stream with random stalls, scoreboard in order
    held = 1'b0;
    hold_val = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      drive(8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom_range(0, 7)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held) check("rnd_hold", {out_valid, obs_pack()}, {1'b1, hold_val});
      held     = out_valid && !out_ready;
      hold_val = obs_pack();
      if (out_valid && out_ready) begin
        check("rnd_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_v = sb.pop_front();
          check("rnd_result", obs_pack(), exp_v);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(op_a, op_b, op_sel, num_mode));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 10;
    while (sb.size() != 0 && budget > 0) begin
      #1;
      if (out_valid) begin
        exp_v = sb.pop_front();
        check("drain_result", obs_pack(), exp_v);
      end
      budget--;
      @(negedge clk);
    end
    check("drain_empty", sb.size(), 0);
    #1 check("drain_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
